countdown_timer: RTL and testbench

Loadable down-counter that complements the team's up-counter. It takes a preset count and decrements it to zero under an enable, then flags terminal count with a one-cycle `done` pulse. Optional auto-reload turns it into a periodic tick generator. It serves as the timeout/interval generator next to the up-counter in the lab datapath.

---
 rtl/countdown_timer_if.sv | 36 +++
 rtl/countdown_timer.sv | 92 +++++++++
 tb/tb_countdown_timer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Bundle for the countdown timer's control inputs and status outputs.
// master drives the controls; slave is the timer itself.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] preset;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output en,
        output load,
        output preset,
        output auto_reload,
        input  count,
        input  busy,
        input  done,
        input  zero
    );

    modport slave (
        input  en,
        input  load,
        input  preset,
        input  auto_reload,
        output count,
        output busy,
        output done,
        output zero
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// Two states: IDLE (count parked, en ignored) and RUN (count decrements
// under en). done is a registered one-cycle pulse after each expiry.
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             done_reg;
    logic             done_next;

    // State register: reset wins over everything, otherwise take the next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= ZERO;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic: load beats decrement; a zero preset expires at once.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.load) begin
                    count_next = bus.preset;
                    if (bus.preset != ZERO) begin
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.load) begin
                    // A load at the terminal edge suppresses the expiry.
                    count_next = bus.preset;
                    if (bus.preset == ZERO) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else if (bus.en) begin
                    if (count_reg == ONE) begin
                        done_next = 1'b1;
                        if (bus.auto_reload && (bus.preset != ZERO)) begin
                            count_next = bus.preset;
                        end else begin
                            count_next = ZERO;
                            state_next = IDLE;
                        end
                    end else if (count_reg != ZERO) begin
                        // Guard keeps the counter from wrapping even if RUN/0 were reached.
                        count_next = count_reg - ONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                count_next = ZERO;
            end
        endcase
    end

    // Outputs: busy and count come straight from registers; zero is a decode of count.
    always_comb begin
        bus.count = count_reg;
        bus.busy  = (state_reg == RUN);
        bus.done  = done_reg;
        bus.zero  = (count_reg == ZERO);
    end
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: each stimulus step pushes the
// expected post-edge outputs; a monitor pops and compares after each edge.
module tb_countdown_timer;
    localparam int WIDTH = 8;

    typedef struct {
        string          name;
        logic [WIDTH-1:0] c;
        logic           b;
        logic           d;
        logic           z;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    countdown_timer_if #(.WIDTH(WIDTH)) bus ();

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle; sample 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (bus.count !== e.c || bus.busy !== e.b || bus.done !== e.d || bus.zero !== e.z) begin
                errors++;
                $display("FAIL %s: got count=%02h busy=%b done=%b zero=%b, want count=%02h busy=%b done=%b zero=%b",
                         e.name, bus.count, bus.busy, bus.done, bus.zero, e.c, e.b, e.d, e.z);
            end else begin
                $display("ok   %s: count=%02h busy=%b done=%b zero=%b",
                         e.name, bus.count, bus.busy, bus.done, bus.zero);
            end
        end
    end

    // Drive inputs on the falling edge, push expectation, let the rising edge happen.
    task automatic step(input string name, input logic r, input logic ld,
                        input logic [WIDTH-1:0] pre, input logic en, input logic ar,
                        input logic [WIDTH-1:0] ec, input logic eb, input logic ed);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.load        = ld;
        bus.preset      = pre;
        bus.en          = en;
        bus.auto_reload = ar;
        e.name = name;
        e.c    = ec;
        e.b    = eb;
        e.d    = ed;
        e.z    = (ec == '0);
        sb_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.load = 1'b0;
        bus.preset = '0;
        bus.en = 1'b0;
        bus.auto_reload = 1'b0;

        // Reset with load asserted: reset must win.
        step("reset0", 1, 1, 8'h05, 0, 0, 8'h00, 0, 0);
        step("reset1", 1, 1, 8'h05, 0, 0, 8'h00, 0, 0);
        step("idle",   0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        // Basic countdown from 3.
        step("basic_load", 0, 1, 8'd3, 1, 0, 8'd3, 1, 0);
        step("basic_2",    0, 0, 8'd3, 1, 0, 8'd2, 1, 0);
        step("basic_1",    0, 0, 8'd3, 1, 0, 8'd1, 1, 0);
        step("basic_exp",  0, 0, 8'd3, 1, 0, 8'd0, 0, 1);
        step("basic_post", 0, 0, 8'd3, 1, 0, 8'd0, 0, 0);

        // Enable gating: en pattern 1,0,0,1,1,1.
        step("gate_load", 0, 1, 8'd4, 0, 0, 8'd4, 1, 0);
        step("gate_e1",   0, 0, 8'd4, 1, 0, 8'd3, 1, 0);
        step("gate_e0a",  0, 0, 8'd4, 0, 0, 8'd3, 1, 0);
        step("gate_e0b",  0, 0, 8'd4, 0, 0, 8'd3, 1, 0);
        step("gate_e1a",  0, 0, 8'd4, 1, 0, 8'd2, 1, 0);
        step("gate_e1b",  0, 0, 8'd4, 1, 0, 8'd1, 1, 0);
        step("gate_exp",  0, 0, 8'd4, 1, 0, 8'd0, 0, 1);
        step("gate_post", 0, 0, 8'd4, 0, 0, 8'd0, 0, 0);

        // Auto-reload with preset 2: done every second edge, busy held.
        step("ar_load", 0, 1, 8'd2, 1, 1, 8'd2, 1, 0);
        step("ar_1a",   0, 0, 8'd2, 1, 1, 8'd1, 1, 0);
        step("ar_rl_a", 0, 0, 8'd2, 1, 1, 8'd2, 1, 1);
        step("ar_1b",   0, 0, 8'd2, 1, 1, 8'd1, 1, 0);
        step("ar_rl_b", 0, 0, 8'd2, 1, 1, 8'd2, 1, 1);
        step("ar_1c",   0, 0, 8'd2, 1, 1, 8'd1, 1, 0);
        step("ar_rl_c", 0, 0, 8'd2, 1, 1, 8'd2, 1, 1);
        step("ar_off1", 0, 0, 8'd2, 1, 0, 8'd1, 1, 0);
        step("ar_offx", 0, 0, 8'd2, 1, 0, 8'd0, 0, 1);
        step("ar_post", 0, 0, 8'd2, 1, 0, 8'd0, 0, 0);

        // Preset 1 with auto-reload: done stays high, one pulse per edge.
        step("p1_load", 0, 1, 8'd1, 1, 1, 8'd1, 1, 0);
        step("p1_a",    0, 0, 8'd1, 1, 1, 8'd1, 1, 1);
        step("p1_b",    0, 0, 8'd1, 1, 1, 8'd1, 1, 1);
        step("p1_stop", 0, 0, 8'd1, 1, 0, 8'd0, 0, 1);
        step("p1_post", 0, 0, 8'd1, 1, 0, 8'd0, 0, 0);

        // Load at the terminal edge suppresses expiry.
        step("lp_load",  0, 1, 8'd2, 1, 0, 8'd2, 1, 0);
        step("lp_1",     0, 0, 8'd2, 1, 0, 8'd1, 1, 0);
        step("lp_reld",  0, 1, 8'd6, 1, 0, 8'd6, 1, 0);
        step("lp_hold",  0, 0, 8'd9, 0, 0, 8'd6, 1, 0);
        step("lp_zero",  0, 1, 8'd0, 1, 0, 8'd0, 0, 1);
        step("lp_post",  0, 0, 8'd0, 0, 0, 8'd0, 0, 0);
        step("idle_z",   0, 1, 8'd0, 0, 0, 8'd0, 0, 1);
        step("idle_zp",  0, 0, 8'd0, 0, 0, 8'd0, 0, 0);

        // Max preset, reset mid-run, then no underflow from IDLE.
        step("max_load", 0, 1, 8'hFF, 1, 0, 8'hFF, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            step($sformatf("max_dec%0d", i), 0, 0, 8'hFF, 1, 0, 8'(8'hFF - i), 1, 0);
        end
        step("mid_rst", 1, 0, 8'hFF, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("nowrap%0d", i), 0, 0, 8'hFF, 1, 0, 8'h00, 0, 0);
        end

        // Let the monitor drain the last expectation.
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
